// File: rtl/soc_bus_pkg.sv
// +----------------------------------------------------------------------------+
// | soc_bus_pkg                                                                 |
// | Shared encodings for the memory-bus arbiter, its decoder and benches.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package soc_bus_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_DATA  = 1'b0,
        OWNER_FETCH = 1'b1
    } owner_t;

endpackage : soc_bus_pkg

`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter_if                                                          |
// | Fetch, data and memory-side handshake signals of the bus arbiter.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Instruction-fetch port
    logic                      i_req;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic                      i_gnt;
    logic                      i_rvalid;
    logic [DATA_WIDTH-1:0]     i_rdata;

    // Data load/store port
    logic                      d_req;
    logic                      d_we;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic [DATA_WIDTH/8-1:0]   d_wstrb;
    logic                      d_gnt;
    logic                      d_rvalid;
    logic [DATA_WIDTH-1:0]     d_rdata;

    // Shared memory port
    logic                      m_req;
    logic                      m_we;
    logic [ADDR_WIDTH-1:0]     m_addr;
    logic [DATA_WIDTH-1:0]     m_wdata;
    logic [DATA_WIDTH/8-1:0]   m_wstrb;
    logic                      m_gnt;
    logic                      m_rvalid;
    logic [DATA_WIDTH-1:0]     m_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  m_gnt, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb
    );

    // CPU and memory side
    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output m_gnt, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb
    );

endinterface : mem_bus_arbiter_if

`default_nettype wire

// File: rtl/arb_select.sv
// +----------------------------------------------------------------------------+
// | arb_select                                                                  |
// | Data-priority owner select with a starvation streak counter for fetch.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module arb_select
    import soc_bus_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1)
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    input  wire logic   i_fetch_req,
    input  wire logic   i_data_req,
    input  wire logic   i_grant_fire,
    input  owner_t      i_grant_owner,
    output owner_t      o_sel_owner
);

    localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] c_streak_one = STREAK_W'(1);

    logic [STREAK_W-1:0] r_streak;
    owner_t              w_sel_owner;

    always_comb begin
        w_sel_owner = OWNER_DATA;
        if (i_fetch_req && !i_data_req) begin
            w_sel_owner = OWNER_FETCH;
        end else if (i_fetch_req && i_data_req && (r_streak == c_streak_max)) begin
            w_sel_owner = OWNER_FETCH;
        end
    end

    assign o_sel_owner = w_sel_owner;

    // Streak only counts data grants that actually made a fetch wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_streak <= '0;
        end else if (i_grant_fire) begin
            if ((i_grant_owner == OWNER_FETCH) || !i_fetch_req) begin
                r_streak <= '0;
            end else if (r_streak != c_streak_max) begin
                r_streak <= r_streak + c_streak_one;
            end
        end
    end

endmodule : arb_select

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter                                                             |
// | Single-outstanding arbiter of fetch and data ports onto one memory port.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter
    import soc_bus_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input wire logic          clk,
    input wire logic          reset_n,
    mem_bus_arbiter_if.slave  bus
);

    arb_state_t               r_state;
    owner_t                   r_owner;
    owner_t                   w_sel_owner;
    owner_t                   w_owner;
    logic                     w_m_req;
    logic                     w_fire;
    logic                     w_resp;
    logic                     w_m_we;
    logic [ADDR_WIDTH-1:0]    w_m_addr;
    logic [DATA_WIDTH-1:0]    w_m_wdata;
    logic [DATA_WIDTH/8-1:0]  w_m_wstrb;

    arb_select #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_arb_select (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_fetch_req   (bus.i_req),
        .i_data_req    (bus.d_req),
        .i_grant_fire  (w_fire),
        .i_grant_owner (w_owner),
        .o_sel_owner   (w_sel_owner)
    );

    // In IDLE the owner follows the live select; once presented it is locked.
    always_comb begin
        w_owner = r_owner;
        if (r_state == ARB_IDLE) begin
            w_owner = w_sel_owner;
        end
    end

    assign w_m_req = (r_state == ARB_REQ) ||
                     ((r_state == ARB_IDLE) && (bus.i_req || bus.d_req));
    assign w_fire  = w_m_req && bus.m_gnt;
    assign w_resp  = (r_state == ARB_WAIT) && bus.m_rvalid;

    always_comb begin
        w_m_we    = 1'b0;
        w_m_addr  = '0;
        w_m_wdata = '0;
        w_m_wstrb = '0;
        if (w_m_req) begin
            if (w_owner == OWNER_FETCH) begin
                w_m_addr = bus.i_addr;
            end else begin
                w_m_we    = bus.d_we;
                w_m_addr  = bus.d_addr;
                w_m_wdata = bus.d_wdata;
                w_m_wstrb = bus.d_wstrb;
            end
        end
    end

    assign bus.m_req   = w_m_req;
    assign bus.m_we    = w_m_we;
    assign bus.m_addr  = w_m_addr;
    assign bus.m_wdata = w_m_wdata;
    assign bus.m_wstrb = w_m_wstrb;

    assign bus.i_gnt    = w_fire && (w_owner == OWNER_FETCH);
    assign bus.d_gnt    = w_fire && (w_owner == OWNER_DATA);
    assign bus.i_rvalid = w_resp && (r_owner == OWNER_FETCH);
    assign bus.d_rvalid = w_resp && (r_owner == OWNER_DATA);
    assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;

    // Responses outside WAIT are spurious and leave the state untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_owner <= OWNER_DATA;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_m_req) begin
                        r_owner <= w_sel_owner;
                        if (bus.m_gnt) begin
                            r_state <= ARB_WAIT;
                        end else begin
                            r_state <= ARB_REQ;
                        end
                    end
                end
                ARB_REQ: begin
                    if (bus.m_gnt) begin
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (bus.m_rvalid) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule : mem_bus_arbiter

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_bus_arbiter                                                          |
// | Cycle-vector table plus hand-written starvation and reset sequences.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int c_aw  = 32;
    localparam int c_dw  = 32;
    localparam int c_max = 4;
    localparam int c_ow  = 138;

    typedef struct {
        logic              i_req;
        logic [31:0]       i_addr;
        logic              d_req;
        logic              d_we;
        logic [31:0]       d_addr;
        logic [31:0]       d_wdata;
        logic [3:0]        d_wstrb;
        logic              m_gnt;
        logic              m_rvalid;
        logic [31:0]       m_rdata;
        logic [c_ow-1:0]   exp_out;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   mdl_streak;
    vec_t vecs[$];

    mem_bus_arbiter_if #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) bus ();

    mem_bus_arbiter #(
        .ADDR_WIDTH      (c_aw),
        .DATA_WIDTH      (c_dw),
        .MAX_DATA_STREAK (c_max)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [c_ow-1:0] ex(
        input logic ig, input logic iv, input logic [31:0] ird,
        input logic dg, input logic dv, input logic [31:0] drd,
        input logic mq, input logic mw, input logic [31:0] ma,
        input logic [31:0] mwd, input logic [3:0] ms);
        return {ig, iv, ird, dg, dv, drd, mq, mw, ma, mwd, ms};
    endfunction

    function automatic logic [c_ow-1:0] act_out();
        return {bus.i_gnt, bus.i_rvalid, bus.i_rdata,
                bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb};
    endfunction

    task automatic add(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da,
        input logic [31:0] dwd, input logic [3:0] ds,
        input logic mg, input logic mv, input logic [31:0] mr,
        input logic [c_ow-1:0] e);
        vec_t v;
        v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd; v.d_wstrb = ds;
        v.m_gnt = mg; v.m_rvalid = mv; v.m_rdata = mr;
        v.exp_out = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.i_req    = v.i_req;
        bus.i_addr   = v.i_addr;
        bus.d_req    = v.d_req;
        bus.d_we     = v.d_we;
        bus.d_addr   = v.d_addr;
        bus.d_wdata  = v.d_wdata;
        bus.d_wstrb  = v.d_wstrb;
        bus.m_gnt    = v.m_gnt;
        bus.m_rvalid = v.m_rvalid;
        bus.m_rdata  = v.m_rdata;
    endtask

    task automatic check(input string name, input logic [c_ow-1:0] act,
                         input logic [c_ow-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    endtask

    // Both ports request; memory grants at once. Bench model predicts the owner.
    task automatic both_grant(input string tag, output bit was_fetch);
        bit exp_fetch;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h80;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
        bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;
        bus.m_gnt = 1'b1; bus.m_rvalid = 1'b0;
        #2;
        exp_fetch = (mdl_streak == c_max);
        check({tag, "_gnt"}, {bus.i_gnt, bus.d_gnt, bus.m_addr},
              {exp_fetch, ~exp_fetch, (exp_fetch ? 32'h80 : 32'h400)});
        if (exp_fetch) mdl_streak = 0;
        else if (mdl_streak < c_max) mdl_streak++;
        was_fetch = exp_fetch;
    endtask

    task automatic both_resp(input string tag, input bit was_fetch);
        @(negedge clk);
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hC0DE0000 + 32'(n_cmp);
        #2;
        check({tag, "_rsp"}, {bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata},
              {was_fetch, ~was_fetch,
               (was_fetch ? bus.m_rdata : 32'h0), (was_fetch ? 32'h0 : bus.m_rdata)});
    endtask

    initial begin
        bit f;
        n_cmp = 0;
        n_err = 0;
        mdl_streak = 0;
        idle_inputs();
        reset_n = 1'b0;

        //   i_req i_addr    d_req we d_addr    d_wdata       strb  gnt rv m_rdata
        add(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
            ex(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0));
        // ORI-style fetch: grant in cycle 0, response next cycle
        add(1'b1, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
            ex(1, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0));
        add(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'h0FF06293,
            ex(0, 1, 32'h0FF06293, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0));
        // Simultaneous rise: data write wins, fetch follows after d_rvalid
        add(1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0,
            ex(0, 0, 32'h0, 1, 0, 32'h0, 1, 1, 32'h100, 32'hFFFFFFFF, 4'hF));
        add(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'hA5A5A5A5,
            ex(0, 0, 32'h0, 0, 1, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0, 4'h0));
        add(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
            ex(1, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h40, 32'h0, 4'h0));
        add(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'h00000013,
            ex(0, 1, 32'h13, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0));
        // Fetch with m_gnt withheld 3 cycles; data rises mid-wait
        add(1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
            ex(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h44, 32'h0, 4'h0));
        add(1'b1, 32'h44, 1'b1, 1'b0, 32'h200, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
            ex(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h44, 32'h0, 4'h0));
        add(1'b1, 32'h44, 1'b1, 1'b0, 32'h200, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
            ex(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h44, 32'h0, 4'h0));
        add(1'b1, 32'h44, 1'b1, 1'b0, 32'h200, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
            ex(1, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h44, 32'h0, 4'h0));
        add(1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11111111,
            ex(0, 1, 32'h11111111, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0));
        add(1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
            ex(0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 32'h200, 32'h0, 4'h0));
        add(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF,
            ex(0, 0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 4'h0));
        // Spurious responses in IDLE and REQ are ignored
        add(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'h55,
            ex(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0));
        add(1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b0, 1'b1, 32'h66,
            ex(0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h300, 32'h12345678, 4'h3));
        add(1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b0, 1'b1, 32'h77,
            ex(0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h300, 32'h12345678, 4'h3));
        add(1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b1, 1'b0, 32'h0,
            ex(0, 0, 32'h0, 1, 0, 32'h0, 1, 1, 32'h300, 32'h12345678, 4'h3));
        add(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'h0,
            ex(0, 0, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0));

        repeat (2) @(negedge clk);
        #2;
        check("in_reset", act_out(), '0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check($sformatf("vec%0d", i), act_out(), vecs[i].exp_out);
        end

        // Continuous contention: 4 data grants, then a fetch, repeated
        mdl_streak = 0;
        for (int t = 0; t < 10; t++) begin
            both_grant($sformatf("streak%0d", t), f);
            both_resp($sformatf("streak%0d", t), f);
        end

        // Reset while WAITing on a data access that pushed streak to its limit
        for (int t = 0; t < 3; t++) begin
            both_grant($sformatf("pre%0d", t), f);
            both_resp($sformatf("pre%0d", t), f);
        end
        both_grant("pre3", f);
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        #2;
        check("mid_reset", act_out(), '0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.m_rvalid = 1'b1;
        bus.m_rdata = 32'hBADBAD00;
        #2;
        check("late_rsp", act_out(), '0);
        mdl_streak = 0;
        for (int t = 0; t < 2; t++) begin
            both_grant($sformatf("post%0d", t), f);
            both_resp($sformatf("post%0d", t), f);
        end

        @(negedge clk);
        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_bus_arbiter

`default_nettype wire
